// File: rtl/seq_shifter.sv
// ============================================================================
//  Module   : seq_shifter
//  Brief    : Iterative SLL/SRL/SRA/ROR shifter, one position per clock under
//             a start/busy/done handshake. Define SEQ_SHIFTER_RADIX4_EN to
//             retire two positions per clock with identical results.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shifted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] c_one = SHW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_op;

    logic [WIDTH-1:0] w_step1;
    logic [WIDTH-1:0] w_next;
    logic [SHW-1:0]   w_cnt_next;

    // Single-position step; the SRA fill bit comes from the register being shifted.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] w,
                                                input logic [1:0]       o);
        logic [WIDTH-1:0] res;
        case (o)
            2'b00:   res = {w[WIDTH-2:0], 1'b0};
            2'b01:   res = {1'b0, w[WIDTH-1:1]};
            2'b10:   res = {w[WIDTH-1], w[WIDTH-1:1]};
            default: res = {w[0], w[WIDTH-1:1]};
        endcase
        return res;
    endfunction

    assign w_step1 = f_step(r_work, r_op);

`ifdef SEQ_SHIFTER_RADIX4_EN
    localparam logic [SHW-1:0] c_two = SHW'(2);

    logic [WIDTH-1:0] w_step2;

    // Two chained steps give exactly the two-bit fill/rotate of each op.
    assign w_step2 = f_step(w_step1, r_op);

    always_comb begin
        w_next     = w_step1;
        w_cnt_next = r_cnt - c_one;
        if (r_cnt >= c_two) begin
            w_next     = w_step2;
            w_cnt_next = r_cnt - c_two;
        end
    end
`else
    assign w_next     = w_step1;
    assign w_cnt_next = r_cnt - c_one;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            shifted <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                // DONE accepts a new request just like IDLE for back-to-back issue.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_work  <= src;
                        r_cnt   <= shamt;
                        r_op    <= op;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_work <= w_next;
                        r_cnt  <= w_cnt_next;
                    end else begin
                        shifted <= r_work;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
// ============================================================================
//  Module   : tb_seq_shifter
//  Brief    : Directed self-checking bench for seq_shifter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] shifted;

    int n_checks = 0;
    int n_pass   = 0;

    seq_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .src     (src),
        .shamt   (shamt),
        .op      (op),
        .busy    (busy),
        .done    (done),
        .shifted (shifted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic int lat_of(input int s);
`ifdef SEQ_SHIFTER_RADIX4_EN
        return (s + 1) / 2 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Called 1ns after a rising edge; returns 1ns after the accept edge.
    task automatic issue(input string tag, input logic [31:0] s, input logic [4:0] a,
                         input logic [1:0] o);
        src   = s;
        shamt = a;
        op    = o;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_accept_busy"}, 32'(busy), 32'd1);
    endtask

    // offset = edges already elapsed since the accept edge.
    task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat,
                             input int offset);
        int          lat      = offset;
        int          busy_cnt = 0;
        bit          seen     = 1'b0;
        bit          stable   = 1'b1;
        logic [31:0] held     = shifted;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cnt++;
                if (shifted !== held) stable = 1'b0;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1 - offset));
        check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
        check({tag, "_shifted_stable"}, 32'(stable), 32'd1);
        check({tag, "_result"}, shifted, exp);
    endtask

    initial begin
        int n_done;

        rst_n = 1'b0;
        start = 1'b0;
        src   = '0;
        shamt = '0;
        op    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_shifted", shifted, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_shifted", shifted, 32'h0);
        end

        issue("sra4", 32'h8000_0000, 5'd4, 2'b10);
        wait_done("sra4", 32'hF800_0000, lat_of(4), 0);
        @(posedge clk); #1;
        check("sra4_done_pulse_one", 32'(done), 32'd0);

        issue("srl4", 32'h8000_0000, 5'd4, 2'b01);
        wait_done("srl4", 32'h0800_0000, lat_of(4), 0);
        @(posedge clk); #1;

        issue("sll31", 32'h0000_0001, 5'd31, 2'b00);
        wait_done("sll31", 32'h8000_0000, lat_of(31), 0);
        @(posedge clk); #1;

        issue("ror1", 32'h0000_0001, 5'd1, 2'b11);
        wait_done("ror1", 32'h8000_0000, lat_of(1), 0);
        // Back-to-back issue from the DONE cycle.
        issue("b2b0", 32'h1234_5678, 5'd0, 2'b00);
        wait_done("b2b0", 32'h1234_5678, lat_of(0), 0);
        @(posedge clk); #1;
        check("b2b0_done_drop", 32'(done), 32'd0);

        issue("ror12", 32'h1234_5678, 5'd12, 2'b11);
        wait_done("ror12", 32'h6781_2345, lat_of(12), 0);
        @(posedge clk); #1;

        issue("sra5pos", 32'h7FFF_FFFF, 5'd5, 2'b10);
        wait_done("sra5pos", 32'h03FF_FFFF, lat_of(5), 0);
        @(posedge clk); #1;

        // A start pulse while busy must be ignored and new inputs not resampled.
        issue("busy_ign", 32'h0000_F000, 5'd8, 2'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        src   = 32'hFFFF_FFFF;
        shamt = 5'd1;
        op    = 2'b00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_ign", 32'h0000_00F0, lat_of(8), 3);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("busy_ign_no_second_done", 32'(n_done), 32'd0);
        check("busy_ign_idle_busy", 32'(busy), 32'd0);

        issue("abort", 32'h0000_0003, 5'd20, 2'b00);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_shifted", shifted, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_shifted_after", shifted, 32'h0);

        issue("post_rst", 32'hF000_000F, 5'd3, 2'b11);
        wait_done("post_rst", 32'hFE00_0001, lat_of(3), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
